// File: rtl/general_addr_scanner.sv
// Streams out the index of every set bit of a captured flag vector, lowest-first or
// highest-first, one index per cycle over a valid/ready handshake.
module general_addr_scanner #(
    parameter int DATA_NUM  = 40,
    parameter int NUM_WIDTH = $clog2(DATA_NUM),
    parameter int CNT_WIDTH = NUM_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [DATA_NUM-1:0]  data,
    input  logic                 abort,
    output logic                 busy,
    output logic                 addr_valid,
    input  logic                 addr_ready,
    output logic [NUM_WIDTH-1:0] addr,
    output logic                 addr_last,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] hit_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic                 mode_r;
    logic [DATA_NUM-1:0]  shadow;
    logic [DATA_NUM-1:0]  shadow_rev;
    logic [DATA_NUM-1:0]  iso_fwd;
    logic [DATA_NUM-1:0]  iso_rev;
    logic [DATA_NUM-1:0]  sel_oh;
    logic [DATA_NUM-1:0]  shadow_next;
    logic [NUM_WIDTH-1:0] idx_fwd;
    logic [NUM_WIDTH-1:0] idx_rev;
    logic [NUM_WIDTH-1:0] sel_idx;
    logic                 load;

    // Descending order reuses the lowest-set-bit isolation on the mirrored vector.
    always_comb begin
        shadow_rev = '0;
        for (int unsigned i = 0; i < DATA_NUM; i++) begin
            shadow_rev[i] = shadow[DATA_NUM-1-i];
        end
    end

    assign iso_fwd = shadow & ~(shadow - DATA_NUM'(1));
    assign iso_rev = shadow_rev & ~(shadow_rev - DATA_NUM'(1));

    always_comb begin
        idx_fwd = '0;
        idx_rev = '0;
        sel_oh  = '0;
        for (int unsigned i = 0; i < DATA_NUM; i++) begin
            if (iso_fwd[i]) idx_fwd = idx_fwd | NUM_WIDTH'(i);
            if (iso_rev[i]) idx_rev = idx_rev | NUM_WIDTH'(i);
            sel_oh[i] = mode_r ? iso_rev[DATA_NUM-1-i] : iso_fwd[i];
        end
        sel_idx = mode_r ? (NUM_WIDTH'(DATA_NUM - 1) - idx_rev) : idx_fwd;
    end

    assign shadow_next = shadow & ~sel_oh;
    assign load        = (state == ST_SCAN) && (!addr_valid || addr_ready);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_r     <= 1'b0;
            shadow     <= '0;
            addr       <= '0;
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
            hit_count  <= '0;
        end else begin
            if (addr_valid && addr_ready) hit_count <= hit_count + CNT_WIDTH'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shadow    <= data;
                        mode_r    <= mode;
                        hit_count <= '0;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        addr_valid <= 1'b0;
                        addr_last  <= 1'b0;
                        shadow     <= '0;
                    end else if (load) begin
                        if (shadow != '0) begin
                            addr       <= sel_idx;
                            shadow     <= shadow_next;
                            addr_valid <= 1'b1;
                            addr_last  <= (shadow_next == '0);
                        end else begin
                            addr_valid <= 1'b0;
                            addr_last  <= 1'b0;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_general_addr_scanner.sv
// Scoreboard bench: the driver queues the expected index stream from a bit-walk model,
// a monitor compares every presented entry and every done pulse against it.
module tb_general_addr_scanner;

    localparam int DN = 40;
    localparam int NW = 6;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [DN-1:0] data;
    logic          abort;
    logic          busy;
    logic          addr_valid;
    logic          addr_ready;
    logic [NW-1:0] addr;
    logic          addr_last;
    logic          done;
    logic [CW-1:0] hit_count;

    general_addr_scanner #(
        .DATA_NUM  (DN),
        .NUM_WIDTH (NW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .data       (data),
        .abort      (abort),
        .busy       (busy),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr       (addr),
        .addr_last  (addr_last),
        .done       (done),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NW-1:0] a;
        logic          l;
    } exp_t;

    exp_t exp_q[$];
    int   exp_hits;
    int   total = 0;
    int   bad = 0;
    int   done_cnt, hs_cnt, vld_cnt, first_hs, last_hs, done_cyc, start_cyc;
    int   rdy_mode = 0;
    logic rdy_val = 1'b1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready generator: 0 = always ready, 1 = random, 2 = follow rdy_val.
    initial begin
        addr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = ($urandom_range(0, 2) != 0);
                default: addr_ready = rdy_val;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (addr_valid) begin
                    vld_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        check("addr", addr, exp_q[0].a);
                        check("addr_last", addr_last, exp_q[0].l);
                        if (addr_ready) begin
                            void'(exp_q.pop_front());
                            hs_cnt++;
                            if (first_hs < 0) first_hs = cyc;
                            last_hs = cyc;
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_queue_empty", exp_q.size(), 0);
                    check("done_hit_count", hit_count, exp_hits);
                end
            end
        end
    end

    // Model: walk the vector in scan order and list every set bit.
    task automatic issue(input logic [DN-1:0] d, input logic m);
        int n;
        int cnt;
        exp_t e;
        done_cnt = 0; hs_cnt = 0; vld_cnt = 0;
        first_hs = -1; last_hs = -1; done_cyc = -1;
        cnt = $countones(d);
        exp_hits = cnt;
        n = 0;
        for (int i = 0; i < DN; i++) begin
            int b;
            b = m ? (DN - 1 - i) : i;
            if (d[b]) begin
                e.a = NW'(b);
                e.l = (n == cnt - 1);
                exp_q.push_back(e);
                n++;
            end
        end
        start = 1'b1; data = d; mode = m;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        data = DN'({$urandom, $urandom});
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", (done_cnt > 0), 1);
        repeat (2) begin @(posedge clk); #1; end
        check("single_done", done_cnt, 1);
        check("busy_after_done", busy, 0);
        check("hit_count_held", hit_count, exp_hits);
    endtask

    initial begin
        logic [DN-1:0] d;
        rst = 1'b1; start = 1'b0; mode = 1'b0; data = '0; abort = 1'b0;
        exp_hits = 0; done_cnt = 0; hs_cnt = 0; vld_cnt = 0;
        first_hs = -1; last_hs = -1; done_cyc = -1; start_cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", addr_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_last", addr_last, 0);
        check("rst_done", done, 0);
        check("rst_hit_count", hit_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // T1 / T2: two-bit vector both directions, full throughput
        for (int m = 0; m < 2; m++) begin
            rdy_mode = 0;
            issue(40'h5, m[0]);
            wait_done(20);
            check("t12_first_latency", first_hs - start_cyc, 2);
            check("t12_last_cycle", last_hs - start_cyc, 3);
            check("t12_done_cycle", done_cyc - start_cyc, 4);
        end

        // T3: back-pressure on the first entry
        rdy_mode = 2; rdy_val = 1'b0;
        d = '0; d[39] = 1'b1; d[0] = 1'b1;
        issue(d, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rdy_val = 1'b1;
        wait_done(20);
        check("t3_first_hs", first_hs - start_cyc, 5);
        check("t3_last_hs", last_hs - start_cyc, 6);
        check("t3_valid_cycles", vld_cnt, 5);
        rdy_mode = 0;

        // T4: empty vector
        issue('0, 1'($urandom_range(0, 1)));
        wait_done(10);
        check("t4_done_cycle", done_cyc - start_cyc, 2);
        check("t4_valid_cycles", vld_cnt, 0);

        // T5: all ones, descending
        issue('1, 1'b1);
        wait_done(60);
        check("t5_first_hs", first_hs - start_cyc, 2);
        check("t5_last_hs", last_hs - start_cyc, 41);
        check("t5_done_cycle", done_cyc - start_cyc, 42);
        check("t5_hs", hs_cnt, 40);

        // T6: abort after three handshakes, with an ignored start mid-scan
        issue(40'hFF, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; data = 40'hF0_0000_0F00; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        repeat (5) begin @(posedge clk); #1; end
        check("t6_no_done", done_cnt, 0);
        check("t6_hs", hs_cnt, 3);
        check("t6_hit_count", hit_count, 3);
        check("t6_busy", busy, 0);
        check("t6_valid", addr_valid, 0);
        check("t6_last", addr_last, 0);
        issue(40'h80_0000_0001, 1'b1);
        wait_done(20);

        // Async reset mid-scan
        issue(40'hFF_FFFF_FFFF, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", addr_valid, 0);
        check("arst_hit_count", hit_count, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Random vectors, random direction, random back-pressure
        rdy_mode = 1;
        for (int k = 0; k < 25; k++) begin
            d = DN'({$urandom, $urandom});
            case ($urandom_range(0, 4))
                0: d = d & DN'({$urandom, $urandom}) & DN'({$urandom, $urandom});
                1: d = d | DN'({$urandom, $urandom});
                2: if ($urandom_range(0, 1) == 0) d = '0;
                default: ;
            endcase
            issue(d, 1'($urandom_range(0, 1)));
            wait_done(400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
